// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment encodings and hex decode helper for seg7_scan_driver
//
// Contents:
//   SEG_A..SEG_G  bit positions of each segment in a 7-bit pattern (a = bit 0)
//   SEG_TABLE     active-high segment patterns for hex digits 0..F
//   hex_to_seg()  nibble -> active-high segment pattern
package seg7_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Patterns are written g..a, so the leftmost bit is segment g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high 7-segment decoder
//
// Ports:
//   nibble  in   4  hex digit 0..F
//   seg_hi  out  7  active-high segments, seg_hi[0]=a .. seg_hi[6]=g
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_hi
);

    assign seg_hi = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment scan driver with shadow load
//
// Ports:
//   clk       in   1           system clock
//   rst       in   1           synchronous reset, active-high
//   value     in   4*N_DIGITS  hex nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in     in   N_DIGITS    decimal point request per digit
//   blank_in  in   N_DIGITS    force digit dark
//   lz_en     in   1           leading-zero suppression enable
//   load      in   1           capture value/dp_in/blank_in/lz_en into shadow
//   seg       out  7           segments a..g (registered, polarity per SEG_ACTIVE_LOW)
//   dp        out  1           decimal point (registered, polarity per SEG_ACTIVE_LOW)
//   an        out  N_DIGITS    digit enables (registered, polarity per AN_ACTIVE_LOW)
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] value_sh;
    logic [N_DIGITS-1:0]   dp_sh;
    logic [N_DIGITS-1:0]   blank_sh;
    logic                  lz_sh;

    logic [N_DIGITS-1:0]   lz_mask;
    logic                  still_zero;
    logic [3:0]            cur_nibble;
    logic                  cur_dark;
    logic                  cur_dp;
    logic [N_DIGITS-1:0]   cur_an;
    logic [6:0]            dec_seg;
    logic [6:0]            seg_act;
    logic                  dp_act;
    logic [N_DIGITS-1:0]   an_act;

    // lz_mask[k] marks digits above the highest nonzero nibble. Digit 0 is
    // excluded so an all-zero value still shows a single "0".
    always_comb begin
        lz_mask    = '0;
        still_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            if (still_zero && (value_sh[4*k +: 4] == 4'h0)) begin
                lz_mask[k] = 1'b1;
            end else begin
                still_zero = 1'b0;
            end
        end
    end

    // Select the current digit with a compare loop so idx never indexes out of range.
    always_comb begin
        cur_nibble = 4'h0;
        cur_dark   = 1'b1;
        cur_dp     = 1'b0;
        cur_an     = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (int'(idx) == k) begin
                cur_nibble = value_sh[4*k +: 4];
                cur_dark   = blank_sh[k] | (lz_sh & lz_mask[k]);
                cur_dp     = dp_sh[k];
                cur_an[k]  = 1'b1;
            end
        end
    end

    seg7_hex_decode u_decode (
        .nibble (cur_nibble),
        .seg_hi (dec_seg)
    );

    // Slot phase 0 is the anti-ghosting gap: everything dark while the anode switches.
    always_comb begin
        seg_act = 7'h00;
        dp_act  = 1'b0;
        an_act  = '0;
        if ((div_cnt != '0) && !cur_dark) begin
            seg_act = dec_seg;
            dp_act  = cur_dp;
            an_act  = cur_an;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            idx      <= '0;
            value_sh <= '0;
            dp_sh    <= '0;
            blank_sh <= '0;
            lz_sh    <= 1'b0;
            seg      <= SEG_OFF;
            dp       <= DP_OFF;
            an       <= AN_OFF;
        end else begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (load) begin
                value_sh <= value;
                dp_sh    <= dp_in;
                blank_sh <= blank_in;
                lz_sh    <= lz_en;
            end
            seg <= seg_act ^ SEG_OFF;
            dp  <= dp_act ^ DP_OFF;
            an  <= an_act ^ AN_OFF;
        end
    end

endmodule
